q_sync_debounce: RTL and testbench
==================================

Q_SYNC_DEBOUNCE -- requirements
Module: q_sync_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on q_in (legal >= 2).
REQ-002 SHALL have parameter DEB_CYCLES, default 4, consecutive differing samples required to accept a level change (legal >= 1).
REQ-003 SHALL have parameter CNT_W, default 8, width of edge_cnt (legal >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port q_in  input  1  asynchronous level from the D-latch Q output.
REQ-007 SHALL have port clr_cnt  input  1  synchronous clear of edge_cnt.
REQ-008 SHALL have port q_stable  output  1  debounced, synchronized copy of q_in.
REQ-009 SHALL have port rise  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-010 SHALL have port fall  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-011 SHALL have port busy  output  1  high while a candidate change is being qualified.
REQ-012 SHALL have port edge_cnt  output  CNT_W  count of accepted changes.

Function
REQ-013 SHALL pass q_in through SYNC_STAGES flops; the last flop output is the sample s.
REQ-014 SHALL implement FSM states ST_LOW, PEND_HIGH, ST_HIGH, PEND_LOW, all outputs registered.
REQ-015 ST_LOW: s=1 -> PEND_HIGH, run count = 1; s=0 -> stay. Same for ST_HIGH with s=0 -> PEND_LOW.
REQ-016 PEND_x: s equal to q_stable -> return to stable state, count cleared, no output change (glitch rejected).
REQ-017 PEND_x: on the edge that sees the DEB_CYCLES-th consecutive differing sample -> q_stable toggles, state becomes the new stable state, count cleared.
REQ-018 DEB_CYCLES=1: transition accepted on the first differing sample, PEND states not visited, busy stays 0.
REQ-019 Latency from a clean q_in step to q_stable change SHALL be exactly SYNC_STAGES+DEB_CYCLES cycles (6 at defaults).
REQ-020 rise/fall SHALL assert for exactly one cycle, the same cycle q_stable takes its new value; never both high.
REQ-021 busy SHALL be 1 exactly when the state is PEND_HIGH or PEND_LOW.
REQ-022 edge_cnt SHALL increment by 1 per accepted change and saturate at 2^CNT_W-1 (no wrap).
REQ-023 clr_cnt SHALL set edge_cnt to 0 next cycle; clr_cnt coincident with an accepted change -> clear wins, edge_cnt = 0.
REQ-024 clr_cnt SHALL NOT affect FSM, q_stable, rise or fall.

Reset
REQ-025 rst SHALL zero all synchronizer flops, run count and edge_cnt, and set state ST_LOW, q_stable=0, rise=0, fall=0, busy=0.
REQ-026 rst asserted mid-qualification SHALL abandon the pending change; no rise/fall pulse is emitted.
REQ-027 rst SHALL take priority over clr_cnt and over all FSM transitions.

Configuration
REQ-028 Macro Q_SYNC_EDGE_EN defined: rise and fall SHALL be generated per REQ-020.
REQ-029 Macro Q_SYNC_EDGE_EN undefined: rise and fall SHALL be tied to 0 and no edge-pulse logic is built; all other behaviour unchanged, edge_cnt still counts.

Structure
REQ-030 FSM state encodings and the default values of SYNC_STAGES, DEB_CYCLES and CNT_W SHALL live in shared package latch_pkg.
REQ-031 The synchronizer chain SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, rst, d, q).
REQ-032 Expected size: 120-400 lines of RTL total.

Verification
REQ-033 rst=1 for 2 cycles, then q_in=1 held -> q_stable=1 and rise=1 exactly 6 cycles after the step; edge_cnt=1.
REQ-034 q_in=1 pulse of 3 cycles from ST_LOW (defaults) -> busy rises, q_stable stays 0, no rise, edge_cnt unchanged.
REQ-035 Clean 1->0 step from ST_HIGH -> fall pulse one cycle, q_stable=0 after 6 cycles, edge_cnt increments.
REQ-036 CNT_W=2, 5 accepted toggles -> edge_cnt sequence 1,2,3,3,3; clr_cnt with 6th toggle -> edge_cnt=0.
REQ-037 rst asserted on the 3rd cycle of PEND_HIGH -> next cycle state ST_LOW, q_stable=0, busy=0, no rise.
REQ-038 Build without Q_SYNC_EDGE_EN, repeat REQ-033 -> rise and fall constantly 0, q_stable timing identical.

Source files
------------

// File: rtl/latch_pkg.sv
// Shared FSM encodings and default parameters for the latch-output synchronizer/debouncer.
package latch_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last flop.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else     r <= {r[STAGES-2:0], d};
  end

  assign q = r[STAGES-1];

endmodule

// File: rtl/q_sync_debounce.sv
// Synchronizes and debounces the D-latch Q output, counts accepted level changes.
// Define Q_SYNC_EDGE_EN to build the rise/fall pulse outputs; otherwise they are tied low.
module q_sync_debounce
  import latch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr_cnt,
  output logic             q_stable,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output state_e           dbg_state
);

  localparam int RUN_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);

  logic             s;
  state_e           state, state_n;
  logic [RUN_W-1:0] run, run_n;
  logic             q_n;
  logic             accept;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (s)
  );

  // run holds how many consecutive differing samples have been seen so far.
  always_comb begin
    state_n = state;
    run_n   = run;
    q_n     = q_stable;
    accept  = 1'b0;
    unique case (state)
      ST_LOW, ST_HIGH: begin
        if (s != q_stable) begin
          if (DEB_CYCLES == 1) begin
            accept  = 1'b1;
            q_n     = s;
            state_n = s ? ST_HIGH : ST_LOW;
          end else begin
            state_n = (state == ST_LOW) ? PEND_HIGH : PEND_LOW;
            run_n   = RUN_W'(1);
          end
        end
      end
      PEND_HIGH, PEND_LOW: begin
        if (s == q_stable) begin
          state_n = q_stable ? ST_HIGH : ST_LOW;
          run_n   = '0;
        end else if (run == RUN_LAST) begin
          accept  = 1'b1;
          q_n     = s;
          state_n = s ? ST_HIGH : ST_LOW;
          run_n   = '0;
        end else begin
          run_n = run + RUN_W'(1);
        end
      end
      default: begin
        state_n = ST_LOW;
        run_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOW;
      run      <= '0;
      q_stable <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      q_stable <= q_n;
      busy     <= (state_n == PEND_HIGH) || (state_n == PEND_LOW);
      if (clr_cnt)
        edge_cnt <= '0;
      else if (accept && (edge_cnt != {CNT_W{1'b1}}))
        edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

`ifdef Q_SYNC_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & q_n;
      fall <= accept & ~q_n;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_q_sync_debounce.sv
// Bench for q_sync_debounce: three instances (defaults, CNT_W=2, DEB_CYCLES=1) against a run-length model.
module tb_q_sync_debounce;
  import latch_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst, q_in, clr_cnt;

  logic [2:0] qs_v, rise_v, fall_v, busy_v;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  state_e     st0, st1, st2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  q_sync_debounce u_dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_cnt(clr_cnt),
    .q_stable(qs_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0]),
    .edge_cnt(cnt0), .dbg_state(st0)
  );

  q_sync_debounce #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_cnt(clr_cnt),
    .q_stable(qs_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1]),
    .edge_cnt(cnt1), .dbg_state(st1)
  );

  q_sync_debounce #(.DEB_CYCLES(1)) u_deb1 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr_cnt(clr_cnt),
    .q_stable(qs_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2]),
    .edge_cnt(cnt2), .dbg_state(st2)
  );

  // Reference: delayed sample, then a count of consecutive samples that differ from the held level.
  logic sh[SYNC];
  int   deb[3]  = '{4, 4, 1};
  int   cmax[3] = '{255, 3, 255};
  int   m_stable[3], m_run[3], m_cnt[3];
  bit   m_rise[3], m_fall[3];

  task automatic model_step();
    logic s;
    bit acc;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) sh[k] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_stable[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
        m_rise[i] = 0; m_fall[i] = 0;
      end
    end else begin
      s = sh[SYNC-1];
      for (int k = SYNC-1; k > 0; k--) sh[k] = sh[k-1];
      sh[0] = q_in;
      for (int i = 0; i < 3; i++) begin
        acc = 0;
        m_rise[i] = 0; m_fall[i] = 0;
        if (int'(s) != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == deb[i]) begin
            m_stable[i] = int'(s);
            m_run[i] = 0;
            acc = 1;
            m_rise[i] = (s == 1'b1);
            m_fall[i] = (s == 1'b0);
          end
        end else begin
          m_run[i] = 0;
        end
        if (clr_cnt) m_cnt[i] = 0;
        else if (acc && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
  endtask

  function automatic state_e exp_state(int i);
    if (m_run[i] == 0) return (m_stable[i] != 0) ? ST_HIGH : ST_LOW;
    return (m_stable[i] != 0) ? PEND_LOW : PEND_HIGH;
  endfunction

  task automatic chk(string tag, int i, int obs, int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0d expected %0d at %0t", tag, i, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int c, st;
    bit er, ef;
    for (int i = 0; i < 3; i++) begin
      c  = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
      st = (i == 0) ? int'(st0) : (i == 1) ? int'(st1) : int'(st2);
`ifdef Q_SYNC_EDGE_EN
      er = m_rise[i]; ef = m_fall[i];
`else
      er = 0; ef = 0;
`endif
      chk("q_stable", i, int'(qs_v[i]), m_stable[i]);
      chk("rise", i, int'(rise_v[i]), int'(er));
      chk("fall", i, int'(fall_v[i]), int'(ef));
      chk("busy", i, int'(busy_v[i]), int'(m_run[i] != 0));
      chk("edge_cnt", i, c, m_cnt[i]);
      chk("state", i, st, int'(exp_state(i)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int len;
    for (int k = 0; k < SYNC; k++) sh[k] = 1'b0;
    rst = 1'b1; q_in = 1'b0; clr_cnt = 1'b0;
    hold(2);
    rst = 1'b0;
    hold(3);

    // clean rise, then clean fall
    q_in = 1'b1; hold(10);
    q_in = 1'b0; hold(10);

    // three-cycle glitch is rejected
    q_in = 1'b1; hold(3);
    q_in = 1'b0; hold(10);

    clr_cnt = 1'b1; hold(1);
    clr_cnt = 1'b0;

    // five clean toggles, then a sixth whose acceptance edge coincides with clr_cnt
    for (int t = 0; t < 5; t++) begin
      q_in = ~q_in; hold(8);
    end
    q_in = ~q_in;
    hold(5);
    clr_cnt = 1'b1; hold(1);
    clr_cnt = 1'b0; hold(2);

    // reset during the third cycle of PEND_HIGH
    q_in = 1'b0; hold(8);
    q_in = 1'b1; hold(4);
    rst = 1'b1; hold(1);
    rst = 1'b0; q_in = 1'b0; hold(8);

    // random segments of varying length, occasional clear and reset
    for (int seg = 0; seg < 50; seg++) begin
      q_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        clr_cnt = ($urandom_range(0, 15) == 0);
        rst     = ($urandom_range(0, 149) == 0);
        tick();
      end
    end
    rst = 1'b0; clr_cnt = 1'b0;
    hold(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
